// File: rtl/tx_sample_feeder.sv
// Buffers I/Q/phi triples from the baseband processor and releases one triple every
// RATE_DIV clocks; presents zeros until the FIFO is primed and whenever it runs dry.
//
// state       | meaning
// ST_IDLE     | stream stopped or not yet primed; zeros presented at each tick
// ST_RUN      | streaming; each tick pops the FIFO head onto the outputs
// ST_UNDERRUN | FIFO ran dry while streaming; zeros until primed again
module tx_sample_feeder #(
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH       = 16,
   parameter int PRIME_LEVEL = 8,
   parameter int RATE_DIV    = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         en_i,
   input  logic                         s_valid_i,
   output logic                         s_ready_o,
   input  logic [DATA_WIDTH-1:0]        s_i_i,
   input  logic [DATA_WIDTH-1:0]        s_q_i,
   input  logic [DATA_WIDTH-1:0]        s_phi_i,
   output logic [DATA_WIDTH-1:0]        in_data_1_o,
   output logic [DATA_WIDTH-1:0]        in_data_2_o,
   output logic [DATA_WIDTH-1:0]        phi_o,
   output logic                         out_strobe_o,
   output logic [$clog2(DEPTH):0]       level_o,
   output logic                         underflow_o,
   input  logic                         clr_underflow_i
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(RATE_DIV);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_UNDERRUN} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]         level_q, level_d;
   logic [DATA_WIDTH-1:0] mem_i_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_q_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_p_q [DEPTH];
   logic [DATA_WIDTH-1:0] out_i_q, out_q_q, out_p_q;
   logic                  strobe_q, underflow_q, underflow_d;
   logic                  tick, push, pop, fifo_empty, prime_ok;

   assign tick       = (cnt_q == CW'(RATE_DIV - 1));
   assign s_ready_o  = (level_q < LW'(DEPTH));
   assign push       = s_valid_i & s_ready_o;
   assign fifo_empty = (level_q == '0);
   assign prime_ok   = (level_q >= LW'(PRIME_LEVEL));
   // Pop decision uses the state before any transition taken on the same edge.
   assign pop        = tick & (state_q == ST_RUN) & ~fifo_empty;
   assign cnt_d      = tick ? '0 : cnt_q + CW'(1);

   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      underflow_d = underflow_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      if (tick && state_q == ST_RUN && fifo_empty)
         underflow_d = 1'b1;
      else if (clr_underflow_i)
         underflow_d = 1'b0;
      case (state_q)
         ST_IDLE:     if (en_i && prime_ok) state_d = ST_RUN;
         ST_RUN:      if (!en_i) state_d = ST_IDLE;
                      else if (tick && fifo_empty) state_d = ST_UNDERRUN;
         ST_UNDERRUN: if (!en_i) state_d = ST_IDLE;
                      else if (prime_ok) state_d = ST_RUN;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_i_q[wr_ptr_q] <= s_i_i;
         mem_q_q[wr_ptr_q] <= s_q_i;
         mem_p_q[wr_ptr_q] <= s_phi_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_i_q     <= '0;
         out_q_q     <= '0;
         out_p_q     <= '0;
         strobe_q    <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         underflow_q <= underflow_d;
         strobe_q    <= tick;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (tick) begin
            out_i_q <= pop ? mem_i_q[rd_ptr_q] : '0;
            out_q_q <= pop ? mem_q_q[rd_ptr_q] : '0;
            out_p_q <= pop ? mem_p_q[rd_ptr_q] : '0;
         end
      end
   end

   assign in_data_1_o  = out_i_q;
   assign in_data_2_o  = out_q_q;
   assign phi_o        = out_p_q;
   assign out_strobe_o = strobe_q;
   assign level_o      = level_q;
   assign underflow_o  = underflow_q;
endmodule
